holy_axi_arbiter: RTL
=====================

# holy_axi_arbiter

Shares the core's single AXI master between the instruction cache (requester 0) and the data cache (requester 1). It accepts one burst request at a time from either cache and drives the matching AXI read or write burst to completion. It sits between the two caches inside `holy_core` and the `axi_if` master port. Arbitration is round-robin at transaction granularity, so only one burst is outstanding on the bus.

## Interface
- `N_REQ`, 2: number of requesters; index 0 is the I-cache, index 1 is the D-cache.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; fixed beat size is 4 bytes.
- `clk` in 1: single clock for block and bus.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in [N_REQ]: burst request pending.
- `req_ready` out [N_REQ]: one-cycle accept pulse at grant.
- `req_write` in [N_REQ]: 1 = write burst, 0 = read burst.
- `req_addr` in [N_REQ][ADDR_W]: burst start address, 4-byte aligned.
- `req_len` in [N_REQ][8]: AXI len (beats − 1).
- `wdata` in [N_REQ][DATA_W]: write beat data.
- `wvalid` in [N_REQ]: write beat valid.
- `wready` out [N_REQ]: write beat taken.
- `rdata` out DATA_W: read beat data, shared by both requesters.
- `rvalid` out [N_REQ]: read beat for requester i.
- `rlast` out 1: final read beat.
- `done` out [N_REQ]: one-cycle pulse when the transaction completes.
- `err` out [N_REQ]: one-cycle pulse with `done` on an error response or a length mismatch.
- `busy` out 1: a transaction is in progress (state ≠ IDLE).
- `grant_idx` out 1: index of the current or last granted requester (debug).
- `m_axi` master `axi_if`: AXI4 master; only the master-driven signals are driven by this block.

## Operation
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - Evaluate `req_valid`.
  - If both are set, grant the requester not equal to `last_grant`; otherwise grant the single requester.
  - On grant: pulse `req_ready[g]`, latch addr, len and write into registers, set `last_grant <= g`.
  - Next state is AW if write, else AR.
- AR:
  - `arvalid=1`, `araddr/arlen` from the latched values, `arid=g`, `arsize=3'b010`, `arburst=2'b01`.
  - On `arready` go to R.
- R:
  - `rready=1`; caches must accept every beat, with no backpressure.
  - `rvalid[g] = m_axi.rvalid`; `rdata` and `rlast` pass through combinationally.
  - An 8-bit beat counter increments per beat.
  - On the beat with `m_axi.rlast`: pulse `done[g]`, go to IDLE.
  - `err[g]` is raised if any beat had `rresp≠0` (sticky over the burst) or if counter ≠ len at rlast.
- AW:
  - `awvalid=1`, `awid=g`, same size/burst as AR.
  - On `awready` go to W.
- W:
  - `m_axi.wvalid = wvalid[g]`, `m_axi.wdata = wdata[g]`, `wstrb=4'hF`.
  - `wready[g] = m_axi.wready`.
  - `wlast = (counter == len)`; the counter increments on each accepted beat.
  - After the last beat, go to B.
- B:
  - `bready=1`.
  - On `bvalid`: pulse `done[g]`, set `err[g] = (bresp≠0)`, go to IDLE.
- Outputs to the non-granted requester are held at 0 in all states.
- `arvalid` and `awvalid` stay high until their ready; `araddr` and `awaddr` are stable while valid.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - `last_grant=1`, so requester 0 wins the first tie.
  - Counter is 0 and the error flag is clear.
- Grant latency: `req_valid` high in IDLE → `req_ready` pulse in the same cycle; `arvalid`/`awvalid` rise the next cycle.
- Completion: `done` is registered and asserted the cycle after the final R or B handshake; the block returns to IDLE in that same cycle.
- Back-to-back: a new grant is possible in the cycle `done` is high. Minimum idle between bursts is 1 cycle.
- `req_valid` dropping after grant is ignored; the latched transaction runs to completion.
- A `req_valid` that arrives while busy waits; it is never dropped.
- `len=0` gives single-beat bursts: `wlast` is asserted on the first W beat.
- `rst` mid-transaction: immediate return to IDLE with all valids low. The bus slave is reset by the same event; no drain is performed.

## Structure
- The shared package (`holy_core_pkg`) holds:
  - state enum `arb_state_t`;
  - constants `AXI_SIZE_4B=3'b010`, `AXI_BURST_INCR=2'b01`, `AXI_RESP_OKAY=2'b00`.
- The round-robin pick is the natural sub-module: `holy_rr_arbiter` (N_REQ request vector plus last-grant pointer in, one-hot grant out, purely combinational). Everything else stays in one always_ff/always_comb pair.

## Test plan
- Single read: req0 addr 0x1000, len 7 → ARADDR=0x1000, ARLEN=7, ARID=0; 8 `rvalid[0]` pulses; `done[0]` 1 cycle after rlast; `err=0`.
- Single write: req1 addr 0x2000, len 3, data 0xA0..0xA3 → AWLEN=3, 4 W beats with `wlast` on beat 4, `wstrb=F`; `done[1]` after BVALID.
- Tie: both `req_valid` from reset → grant 0 first, then 1; a second tie → 0 again (alternation verified over 4 transactions).
- Error and mismatch: read with len 3 and rresp=2'b10 on beat 2 → `err[0]` with `done[0]`. Read with len 3 and rlast on beat 2 → `err[0]`.
- Stalls: arready/awready low for 5 cycles, and random wready/rvalid gaps → address stable, beat counts correct, no beat routed to the wrong requester.
- Reset mid-burst: assert `rst` during beat 2 of W → next cycle all outputs 0, state IDLE; a fresh req0 is serviced normally.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared types and AXI constants for the holy_core memory subsystem.
package holy_core_pkg;

    // Arbiter transaction phases: one burst is in flight between leaving and re-entering IDLE.
    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_AR   = 3'd1,
        ARB_R    = 3'd2,
        ARB_AW   = 3'd3,
        ARB_W    = 3'd4,
        ARB_B    = 3'd5
    } arb_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_ID_W       = 4;

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (no user/qos/lock/cache/prot fields; IDs only on the request side).
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = holy_core_pkg::AXI_ID_W
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/holy_rr_arbiter.sv
// Combinational round-robin pick: the first pending request after the previous winner.
// The index wrap relies on N_REQ being a power of two.
module holy_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the ring starting just after last_grant; only the first hit is granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last_grant;
        for (int k = 1; k <= N_REQ; k++) begin
            idx        = last_grant + IDX_W'(k);
            grant[idx] = req[idx] & ~found;
            found      = found | req[idx];
        end
    end

endmodule

// File: rtl/holy_axi_arbiter.sv
// Shares one AXI master between the I-cache (0) and D-cache (1), one burst at a time.
module holy_axi_arbiter
    import holy_core_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_write,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][7:0]          req_len,
    input  logic [N_REQ-1:0][DATA_W-1:0]   wdata,
    input  logic [N_REQ-1:0]               wvalid,
    output logic [N_REQ-1:0]               wready,
    output logic [DATA_W-1:0]              rdata,
    output logic [N_REQ-1:0]               rvalid,
    output logic                           rlast,
    output logic [N_REQ-1:0]               done,
    output logic [N_REQ-1:0]               err,
    output logic                           busy,
    output logic [IDX_W-1:0]               grant_idx,
    axi_if.master                          m_axi
);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rerr_q, rerr_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  err_q, err_d;

    logic [N_REQ-1:0]  grant_oh;
    logic [IDX_W-1:0]  pick;

    holy_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant_oh)
    );

    // Encode the one-hot winner into an index.
    always_comb begin
        pick = {IDX_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            pick = pick | (grant_oh[k] ? IDX_W'(k) : {IDX_W{1'b0}});
        end
    end

    // Next-state and bus/requester outputs; everything defaults to idle/zero.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        rerr_d       = rerr_q;
        done_d       = '0;
        err_d        = '0;

        req_ready    = '0;
        wready       = '0;
        rvalid       = '0;
        rdata        = '0;
        rlast        = 1'b0;

        m_axi.awid    = '0;
        m_axi.awaddr  = '0;
        m_axi.awlen   = 8'h00;
        m_axi.awsize  = 3'b000;
        m_axi.awburst = 2'b00;
        m_axi.awvalid = 1'b0;
        m_axi.wdata   = '0;
        m_axi.wstrb   = '0;
        m_axi.wlast   = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arid    = '0;
        m_axi.araddr  = '0;
        m_axi.arlen   = 8'h00;
        m_axi.arsize  = 3'b000;
        m_axi.arburst = 2'b00;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    req_ready    = grant_oh;
                    gnt_d        = pick;
                    last_grant_d = pick;
                    addr_d       = req_addr[pick];
                    len_d        = req_len[pick];
                    cnt_d        = 8'h00;
                    rerr_d       = 1'b0;
                    state_d      = req_write[pick] ? ARB_AW : ARB_AR;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_AR: begin
                m_axi.arvalid = 1'b1;
                m_axi.arid    = AXI_ID_W'(gnt_q);
                m_axi.araddr  = addr_q;
                m_axi.arlen   = len_q;
                m_axi.arsize  = AXI_SIZE_4B;
                m_axi.arburst = AXI_BURST_INCR;
                state_d       = m_axi.arready ? ARB_R : ARB_AR;
            end
            ARB_R: begin
                m_axi.rready  = 1'b1;
                rvalid[gnt_q] = m_axi.rvalid;
                rdata         = m_axi.rdata;
                rlast         = m_axi.rlast;
                if (m_axi.rvalid) begin
                    if (m_axi.rlast) begin
                        // A short or long burst is reported like a bus error.
                        done_d[gnt_q] = 1'b1;
                        err_d[gnt_q]  = rerr_q | (m_axi.rresp != AXI_RESP_OKAY) | (cnt_q != len_q);
                        state_d       = ARB_IDLE;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        rerr_d = rerr_q | (m_axi.rresp != AXI_RESP_OKAY);
                    end
                end else begin
                    state_d = ARB_R;
                end
            end
            ARB_AW: begin
                m_axi.awvalid = 1'b1;
                m_axi.awid    = AXI_ID_W'(gnt_q);
                m_axi.awaddr  = addr_q;
                m_axi.awlen   = len_q;
                m_axi.awsize  = AXI_SIZE_4B;
                m_axi.awburst = AXI_BURST_INCR;
                state_d       = m_axi.awready ? ARB_W : ARB_AW;
            end
            ARB_W: begin
                m_axi.wvalid  = wvalid[gnt_q];
                m_axi.wdata   = wdata[gnt_q];
                m_axi.wstrb   = {(DATA_W/8){1'b1}};
                m_axi.wlast   = (cnt_q == len_q);
                wready[gnt_q] = m_axi.wready;
                if (wvalid[gnt_q] && m_axi.wready) begin
                    if (cnt_q == len_q) begin
                        state_d = ARB_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ARB_W;
                end
            end
            ARB_B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = (m_axi.bresp != AXI_RESP_OKAY);
                    state_d       = ARB_IDLE;
                end else begin
                    state_d = ARB_B;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to the top index so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= {IDX_W{1'b0}};
            last_grant_q <= IDX_W'(N_REQ - 1);
            addr_q       <= '0;
            len_q        <= 8'h00;
            cnt_q        <= 8'h00;
            rerr_q       <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            rerr_q       <= rerr_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != ARB_IDLE);
    assign grant_idx = gnt_q;

endmodule
